prf_free_list: RTL and testbench

- Tracks free physical registers and the retirement-side architectural map.
- Sits between dispatch and ROB commit:
  - Dispatch pulls destination PRNs from it for register-writing instructions.
  - ROB commit returns the previous architectural mapping of each retiring destination.
- On `proc_nuke` it restores itself in one cycle:
  - Every speculatively allocated PRN becomes free again.
  - The architectural map is exported so the rename table can be rebuilt.

---
 rtl/prf_free_list_pkg.sv | 17 +
 rtl/prf_free_list_retire_map.sv | 63 ++++++
 rtl/prf_free_list.sv | 137 +++++++++++++
 tb/tb_prf_free_list.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/prf_free_list_pkg.sv
// prf_free_list_pkg
//   Shared definitions for the physical register free list.
//   - WAYS : dispatch/commit superscalar width
//   - PRF  : number of physical registers (power of two, > REGS)
//   - REGS : number of architectural registers
//   - prn_t / arn_t : physical / architectural register number types
package prf_free_list_pkg;

  localparam int WAYS  = 3;
  localparam int PRF   = 64;
  localparam int REGS  = 32;
  localparam int PRN_W = $clog2(PRF);

  typedef logic [PRN_W-1:0] prn_t;
  typedef logic [4:0]       arn_t;

endpackage

// File: rtl/prf_free_list_retire_map.sv
// prf_free_list_retire_map
//   Retirement-side architectural map. Each committing way looks up the PRN
//   that previously held its ARN (this PRN becomes free) and then installs
//   its own PRN. Older ways in the same commit group that wrote the same ARN
//   are forwarded so the younger way frees the older way's PRN.
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   commit_valid[WAYS]  : way is a committing register writer
//   commit_ARN[WAYS]    : destination architectural register
//   commit_PRN[WAYS]    : destination physical register being retired
//   freed_PRN[WAYS]     : PRN released by each way (combinational)
//   arch_map[REGS]      : registered retirement map
module prf_free_list_retire_map
  import prf_free_list_pkg::*;
#(
  parameter int WAYS = prf_free_list_pkg::WAYS,
  parameter int PRF  = prf_free_list_pkg::PRF,
  parameter int REGS = prf_free_list_pkg::REGS
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [WAYS-1:0]                      commit_valid,
  input  logic [WAYS-1:0][4:0]                 commit_ARN,
  input  logic [WAYS-1:0][$clog2(PRF)-1:0]     commit_PRN,
  output logic [WAYS-1:0][$clog2(PRF)-1:0]     freed_PRN,
  output logic [REGS-1:0][$clog2(PRF)-1:0]     arch_map
);

  localparam int PW = $clog2(PRF);

  logic [REGS-1:0][PW-1:0] r_map;

  assign arch_map = r_map;

  // Freed PRN per way: table lookup, overridden by the youngest older way
  // in the group that retired the same ARN.
  always_comb begin
    freed_PRN = '0;
    for (int i = 0; i < WAYS; i++) begin
      freed_PRN[i] = r_map[commit_ARN[i]];
      for (int j = 0; j < i; j++) begin
        freed_PRN[i] = (commit_valid[j] && (commit_ARN[j] == commit_ARN[i]))
                       ? commit_PRN[j] : freed_PRN[i];
      end
    end
  end

  // Map update: later ways overwrite earlier ones on an ARN collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < REGS; k++) begin
        r_map[k] <= PW'(k);
      end
    end else begin
      for (int i = 0; i < WAYS; i++) begin
        if (commit_valid[i]) begin
          r_map[commit_ARN[i]] <= commit_PRN[i];
        end
      end
    end
  end

endmodule

// File: rtl/prf_free_list.sv
// prf_free_list
//   Circular free list of physical registers between dispatch and ROB commit.
//   head   : next PRN handed out to dispatch (speculative)
//   rhead  : where head would be if only committed allocations existed
//   tail   : where freed PRNs from commit are appended
//   A flush (proc_nuke) snaps head back to rhead, returning every in-flight
//   allocation in one cycle; this works because commit order equals
//   allocation order.
// Ports:
//   clock, reset              : clock and synchronous active-high reset
//   alloc_req[WAYS]           : way needs a destination PRN
//   alloc_ok                  : every request granted this cycle (comb)
//   alloc_PRN[WAYS]           : granted PRN per way, 0 when not granted
//   num_avail                 : registered free count
//   commit_valid/ARN/PRN      : ROB committing register writers
//   proc_nuke                 : ROB flush, alongside the committing group
//   arch_map[REGS]            : registered retirement map
module prf_free_list
  import prf_free_list_pkg::*;
#(
  parameter int WAYS = prf_free_list_pkg::WAYS,
  parameter int PRF  = prf_free_list_pkg::PRF,
  parameter int REGS = prf_free_list_pkg::REGS
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [WAYS-1:0]                      alloc_req,
  output logic                                 alloc_ok,
  output logic [WAYS-1:0][$clog2(PRF)-1:0]     alloc_PRN,
  output logic [$clog2(PRF):0]                 num_avail,
  input  logic [WAYS-1:0]                      commit_valid,
  input  logic [WAYS-1:0][4:0]                 commit_ARN,
  input  logic [WAYS-1:0][$clog2(PRF)-1:0]     commit_PRN,
  input  logic                                 proc_nuke,
  output logic [REGS-1:0][$clog2(PRF)-1:0]     arch_map
);

  localparam int PW = $clog2(PRF);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_fl [0:PRF-1];
  logic [CW-1:0] r_head;
  logic [CW-1:0] r_rhead;
  logic [CW-1:0] r_tail;
  logic [CW-1:0] r_num_avail;

  logic [CW-1:0]           w_n_req;
  logic [CW-1:0]           w_n_commit;
  logic [PW-1:0]           w_alloc_idx [0:WAYS-1];
  logic [PW-1:0]           w_free_idx  [0:WAYS-1];
  logic [WAYS-1:0][PW-1:0] w_freed;
  logic                    w_alloc_ok;
  logic [CW-1:0]           w_head_next;
  logic [CW-1:0]           w_rhead_next;
  logic [CW-1:0]           w_tail_next;

  prf_free_list_retire_map #(
    .WAYS (WAYS),
    .PRF  (PRF),
    .REGS (REGS)
  ) u_retire_map (
    .clock        (clock),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_ARN   (commit_ARN),
    .commit_PRN   (commit_PRN),
    .freed_PRN    (w_freed),
    .arch_map     (arch_map)
  );

  // Compact requesting/committing ways: slot index = pointer + number of
  // active ways below this one (modulo PRF through the truncated add).
  always_comb begin
    w_n_req    = '0;
    w_n_commit = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_alloc_idx[i] = r_head[PW-1:0] + w_n_req[PW-1:0];
      w_free_idx[i]  = r_tail[PW-1:0] + w_n_commit[PW-1:0];
      w_n_req        = w_n_req + CW'(alloc_req[i]);
      w_n_commit     = w_n_commit + CW'(commit_valid[i]);
    end
  end

  assign w_alloc_ok = (w_n_req <= r_num_avail) && !proc_nuke;
  assign alloc_ok   = w_alloc_ok;
  assign num_avail  = r_num_avail;

  // Grant PRNs only when the whole group can be satisfied.
  always_comb begin
    alloc_PRN = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (w_alloc_ok && alloc_req[i]) begin
        alloc_PRN[i] = r_fl[w_alloc_idx[i]];
      end else begin
        alloc_PRN[i] = '0;
      end
    end
  end

  // Pointer next-state; a flush discards speculative allocations by
  // moving head onto the post-commit retirement head.
  always_comb begin
    w_tail_next  = r_tail + w_n_commit;
    w_rhead_next = r_rhead + w_n_commit;
    if (proc_nuke) begin
      w_head_next = w_rhead_next;
    end else if (w_alloc_ok) begin
      w_head_next = r_head + w_n_req;
    end else begin
      w_head_next = r_head;
    end
  end

  // Free list storage, pointers and registered free count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head      <= '0;
      r_rhead     <= '0;
      r_tail      <= CW'(PRF - REGS);
      r_num_avail <= CW'(PRF - REGS);
      for (int k = 0; k < PRF; k++) begin
        r_fl[k] <= (k < PRF - REGS) ? PW'(REGS + k) : '0;
      end
    end else begin
      r_head      <= w_head_next;
      r_rhead     <= w_rhead_next;
      r_tail      <= w_tail_next;
      r_num_avail <= w_tail_next - w_head_next;
      for (int i = 0; i < WAYS; i++) begin
        if (commit_valid[i]) begin
          r_fl[w_free_idx[i]] <= w_freed[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_free_list.sv
module tb_prf_free_list;

  logic              clock;
  logic              reset;
  logic [2:0]        alloc_req;
  logic              alloc_ok;
  logic [2:0][5:0]   alloc_PRN;
  logic [6:0]        num_avail;
  logic [2:0]        commit_valid;
  logic [2:0][4:0]   commit_ARN;
  logic [2:0][5:0]   commit_PRN;
  logic              proc_nuke;
  logic [31:0][5:0]  arch_map;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  prf_free_list #(.WAYS(3), .PRF(64), .REGS(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_ok     (alloc_ok),
    .alloc_PRN    (alloc_PRN),
    .num_avail    (num_avail),
    .commit_valid (commit_valid),
    .commit_ARN   (commit_ARN),
    .commit_PRN   (commit_PRN),
    .proc_nuke    (proc_nuke),
    .arch_map     (arch_map)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Decoder contract: x0 never commits as a register writer.
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      assert (!(commit_valid[i] && commit_ARN[i] == 5'd0))
        else $error("contract violation: way %0d commits ARN 0", i);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alloc_req    = 3'b000;
    commit_valid = 3'b000;
    commit_ARN   = '0;
    commit_PRN   = '0;
    proc_nuke    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    do_reset();

    // Reset state
    #1;
    check("reset_num_avail", int'(num_avail), 32);
    check("reset_arch_map5", int'(arch_map[5]), 5);
    check("reset_idle_ok", int'(alloc_ok), 1);
    check("reset_idle_prn0", int'(alloc_PRN[0]), 0);

    // Full-width allocation from reset
    alloc_req = 3'b111;
    #1;
    check("alloc3_ok", int'(alloc_ok), 1);
    check("alloc3_w0", int'(alloc_PRN[0]), 32);
    check("alloc3_w1", int'(alloc_PRN[1]), 33);
    check("alloc3_w2", int'(alloc_PRN[2]), 34);
    tick();
    idle();
    check("alloc3_avail", int'(num_avail), 29);

    // Sparse request
    do_reset();
    alloc_req = 3'b101;
    #1;
    check("sparse_w0", int'(alloc_PRN[0]), 32);
    check("sparse_w1", int'(alloc_PRN[1]), 0);
    check("sparse_w2", int'(alloc_PRN[2]), 33);
    tick();
    idle();
    check("sparse_avail", int'(num_avail), 30);

    // Commit: x5 gets PRN 32, then retires it, freeing PRN 5 into fl[32]
    do_reset();
    alloc_req = 3'b001;
    #1;
    check("commit_alloc_prn", int'(alloc_PRN[0]), 32);
    tick();
    idle();
    check("commit_pre_avail", int'(num_avail), 31);
    commit_valid  = 3'b001;
    commit_ARN[0] = 5'd5;
    commit_PRN[0] = 6'd32;
    tick();
    idle();
    check("commit_map5", int'(arch_map[5]), 32);
    check("commit_avail", int'(num_avail), 32);
    // Drain fl[1..31] so the next slot is fl[32]
    alloc_req = 3'b111;
    for (int n = 0; n < 10; n++) tick();
    alloc_req = 3'b001;
    tick();
    #1;
    check("drain_avail", int'(num_avail), 1);
    check("freed5_ok", int'(alloc_ok), 1);
    check("freed5_prn", int'(alloc_PRN[0]), 5);
    tick();
    #1;
    check("empty_avail", int'(num_avail), 0);
    check("empty_ok", int'(alloc_ok), 0);
    alloc_req = 3'b000;
    #1;
    check("empty_idle_ok", int'(alloc_ok), 1);

    // Same-ARN commit group: x7->40 then x7->41 frees 7 and 40
    do_reset();
    commit_valid  = 3'b011;
    commit_ARN[0] = 5'd7;
    commit_PRN[0] = 6'd40;
    commit_ARN[1] = 5'd7;
    commit_PRN[1] = 6'd41;
    tick();
    idle();
    check("same_map7", int'(arch_map[7]), 41);
    check("same_map6", int'(arch_map[6]), 6);
    check("same_avail", int'(num_avail), 34);
    alloc_req = 3'b111;
    for (int n = 0; n < 10; n++) tick();
    alloc_req = 3'b011;
    tick();
    #1;
    check("same_free0", int'(alloc_PRN[0]), 7);
    check("same_free1", int'(alloc_PRN[1]), 40);
    idle();

    // Nuke: 20 allocated, 3 commit, then 1 commits with the flush
    do_reset();
    alloc_req = 3'b111;
    for (int n = 0; n < 6; n++) tick();
    alloc_req = 3'b011;
    tick();
    idle();
    check("nuke_pre_avail", int'(num_avail), 12);
    commit_valid = 3'b111;
    commit_ARN   = {5'd3, 5'd2, 5'd1};
    commit_PRN   = {6'd34, 6'd33, 6'd32};
    tick();
    idle();
    check("nuke_mid_avail", int'(num_avail), 15);
    commit_valid  = 3'b001;
    commit_ARN[0] = 5'd4;
    commit_PRN[0] = 6'd35;
    proc_nuke     = 1'b1;
    alloc_req     = 3'b111;
    #1;
    check("nuke_alloc_blocked", int'(alloc_ok), 0);
    tick();
    idle();
    check("nuke_avail", int'(num_avail), 32);
    check("nuke_map4", int'(arch_map[4]), 35);
    check("nuke_map1", int'(arch_map[1]), 32);
    alloc_req = 3'b001;
    #1;
    check("nuke_next_prn", int'(alloc_PRN[0]), 36);
    idle();

    // Near-empty: 30 allocated leaves 2
    do_reset();
    alloc_req = 3'b111;
    for (int n = 0; n < 10; n++) tick();
    #1;
    check("near_avail", int'(num_avail), 2);
    check("near_req3_ok", int'(alloc_ok), 0);
    tick();
    check("near_hold_avail", int'(num_avail), 2);
    alloc_req = 3'b011;
    #1;
    check("near_req2_ok", int'(alloc_ok), 1);
    check("near_req2_w0", int'(alloc_PRN[0]), 62);
    check("near_req2_w1", int'(alloc_PRN[1]), 63);
    tick();
    idle();
    check("near_empty_avail", int'(num_avail), 0);

    // Reset overrides nuke and traffic in the same cycle
    alloc_req     = 3'b111;
    commit_valid  = 3'b001;
    commit_ARN[0] = 5'd3;
    commit_PRN[0] = 6'd50;
    proc_nuke     = 1'b1;
    reset         = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    check("rst_prio_avail", int'(num_avail), 32);
    check("rst_prio_map3", int'(arch_map[3]), 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
